// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus send/ready sequencer feeding a UART transmit controller.
// Producer writes at full rate; bytes are issued one per frame over the handshake.
module uart_tx_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              ovf_clr,
  input  logic              tx_ready,
  output logic              tx_send,
  output logic [7:0]        tx_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_RDY} state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  state_t            state, state_nxt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic              wr_ok, pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign pop     = (state == IDLE) && !empty && tx_ready;
  assign tx_send = (state == SEND);

  // NOTE: storage has no reset; stale contents are unreachable because the
  // pointers and count are reset, and a resettable array would cost a flop per bit.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      tx_data  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        tx_data <= mem[rd_ptr];
      end
      case ({wr_ok, pop})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
      // Set has priority over clear so a drop in the clearing cycle is never lost.
      if (wr_en && full) overflow <= 1'b1;
      else if (ovf_clr)  overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (pop) state_nxt = SEND;
      SEND:      state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (!tx_ready) state_nxt = WAIT_RDY;
      WAIT_RDY:  if (tx_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: vector table plus hand-written sequences,
// with a shortened-bit behavioural UART controller and serial decoder.
module tb_uart_tx_feeder;

  localparam int BIT_CYC = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ovf_clr = 1'b0;
  logic       tx_ready;
  logic       tx_send;
  logic [7:0] tx_data;
  logic       full, empty, overflow;
  logic [4:0] count;

  logic       model_en = 1'b0;
  logic       man_ready = 1'b0;
  logic       m_ready = 1'b1;
  logic       m_line = 1'b1;
  logic [9:0] m_sh = '0;
  int         m_bits = 0;
  int         m_tick = 0;

  int         total = 0;
  int         bad = 0;
  int         pulses = 0;
  logic [7:0] sent_q[$];
  logic [7:0] rx_q[$];

  assign tx_ready = model_en ? m_ready : man_ready;

  uart_tx_feeder #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .ovf_clr(ovf_clr),
    .tx_ready(tx_ready), .tx_send(tx_send), .tx_data(tx_data), .full(full),
    .empty(empty), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Controller model: no reset, latches send while idle, ready drops next cycle.
  always @(posedge clk) begin
    if (m_bits == 0) begin
      m_line  <= 1'b1;
      m_ready <= 1'b1;
      if (model_en && m_ready && tx_send) begin
        m_sh    <= {1'b1, tx_data, 1'b0};
        m_bits  <= 10;
        m_tick  <= 0;
        m_ready <= 1'b0;
      end
    end else begin
      m_line <= m_sh[0];
      if (m_tick == BIT_CYC - 1) begin
        m_tick <= 0;
        m_sh   <= m_sh >> 1;
        m_bits <= m_bits - 1;
      end else begin
        m_tick <= m_tick + 1;
      end
    end
  end

  initial begin : decoder
    logic [7:0] rx_byte;
    forever begin
      @(negedge m_line);
      repeat (BIT_CYC / 2) @(posedge clk);
      for (int b = 0; b < 8; b++) begin
        repeat (BIT_CYC) @(posedge clk);
        rx_byte[b] = m_line;
      end
      repeat (BIT_CYC) @(posedge clk);
      rx_q.push_back(rx_byte);
    end
  end

  always @(negedge clk) begin
    if (tx_send) begin
      pulses++;
      sent_q.push_back(tx_data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int limit, input string name);
    for (int i = 0; i < limit && rx_q.size() < n; i++) @(posedge clk);
    #1;
    check(name, 32'(rx_q.size() >= n), 1);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       rdy;
    logic [4:0] cnt;
    logic       send;
    logic [7:0] txd;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [4:0] prev_cnt;
    logic       acc;
    int         sim_hits;
    int         p0;

    vecs[0]  = '{1'b1, 8'h11, 1'b0, 5'd1, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 8'h22, 1'b0, 5'd2, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 8'h11};
    vecs[3]  = '{1'b1, 8'h33, 1'b1, 5'd2, 1'b0, 8'h11};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 8'h11};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 8'h11};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 8'h11};
    vecs[7]  = '{1'b1, 8'h44, 1'b1, 5'd2, 1'b1, 8'h22};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 8'h22};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 8'h22};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 8'h22};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 8'h22};
    vecs[12] = '{1'b1, 8'h55, 1'b0, 5'd3, 1'b0, 8'h22};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b1, 8'h33};

    // Reset values
    do_reset();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_send", tx_send, 0);
    check("rst_data", tx_data, 8'h00);
    check("rst_ovf", overflow, 0);

    // Vector table, manual ready
    for (int i = 0; i < 14; i++) begin
      wr_en = vecs[i].wr; wr_data = vecs[i].d; man_ready = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d_count", i), count, vecs[i].cnt);
      check($sformatf("vec%0d_send", i), tx_send, vecs[i].send);
      check($sformatf("vec%0d_data", i), tx_data, vecs[i].txd);
      check($sformatf("vec%0d_empty", i), empty, 32'(vecs[i].cnt == 0));
    end
    wr_en = 1'b0;

    // Single byte through the controller model
    do_reset();
    model_en = 1'b1;
    rx_q.delete(); sent_q.delete();
    p0 = pulses;
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    check("single_n1_send", tx_send, 0);
    check("single_n1_count", count, 1);
    tick();
    check("single_n2_send", tx_send, 1);
    check("single_n2_data", tx_data, 8'hA5);
    tick();
    check("single_n3_send", tx_send, 0);
    wait_rx(1, 200, "single_rx_timeout");
    check("single_rx_byte", rx_q.size() > 0 ? rx_q[0] : 8'hxx, 8'hA5);
    check("single_pulses", pulses - p0, 1);
    repeat (2 * BIT_CYC) @(posedge clk);

    // Ordering and draining: fill with ready low, then let the model drain
    model_en = 1'b0; man_ready = 1'b0;
    do_reset();
    rx_q.delete(); sent_q.delete();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1);
      tick();
    end
    wr_en = 1'b0;
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    model_en = 1'b1;
    wait_rx(16, 3000, "drain_rx_timeout");
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_rx%0d", i), i < rx_q.size() ? rx_q[i] : 8'hxx, 8'(i + 1));
      check($sformatf("drain_sent%0d", i), i < sent_q.size() ? sent_q[i] : 8'hxx, 8'(i + 1));
    end
    check("drain_empty", empty, 1);
    repeat (2 * BIT_CYC) @(posedge clk);

    // Overflow
    model_en = 1'b0; man_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h80 + i);
      tick();
      if (i == 15) check("ovf_not_yet", overflow, 0);
    end
    wr_en = 1'b0;
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 16);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);
    wr_en = 1'b1; ovf_clr = 1'b1;
    tick();
    wr_en = 1'b0; ovf_clr = 1'b0;
    check("ovf_set_wins", overflow, 1);
    check("ovf_set_wins_count", count, 16);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    wr_en = 1'b1; man_ready = 1'b1;
    tick();
    wr_en = 1'b0; man_ready = 1'b0;
    check("ovf_pop_full_count", count, 15);
    check("ovf_pop_full_flag", overflow, 1);
    check("ovf_pop_full_data", tx_data, 8'h80);

    // Wrap-around: two bursts of 10 while draining
    do_reset();
    model_en = 1'b1;
    rx_q.delete(); sent_q.delete();
    sim_hits = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        wr_en = 1'b0;
        repeat (300) @(posedge clk);
        #1;
      end
      wr_en = 1'b1; wr_data = 8'(8'h40 + i);
      prev_cnt = count;
      acc = !full;
      tick();
      if (tx_send && acc) begin
        sim_hits++;
        check($sformatf("wrap_simul%0d_count", i), count, prev_cnt);
      end
    end
    wr_en = 1'b0;
    check("wrap_simul_seen", 32'(sim_hits > 0), 1);
    wait_rx(20, 4000, "wrap_rx_timeout");
    check("wrap_sent_n", sent_q.size(), 20);
    for (int i = 0; i < 20; i++)
      check($sformatf("wrap_rx%0d", i), i < rx_q.size() ? rx_q[i] : 8'hxx, 8'(8'h40 + i));
    repeat (2 * BIT_CYC) @(posedge clk);

    // Reset mid-frame with bytes queued
    do_reset();
    rx_q.delete(); sent_q.delete();
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h60 + i);
      tick();
    end
    wr_en = 1'b0;
    repeat (5) tick();
    check("mid_queued", count, 5);
    check("mid_inflight", 32'(m_bits != 0), 1);
    p0 = pulses;
    rst = 1'b1;
    #1;
    check("mid_async_count", count, 0);
    check("mid_async_send", tx_send, 0);
    check("mid_async_empty", empty, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 200 && !m_ready; i++) tick();
    check("mid_ready_back", m_ready, 1);
    check("mid_no_pulse_while_busy", pulses - p0, 0);
    check("mid_still_queued", count, 1);
    repeat (3) tick();
    check("mid_new_pulse", pulses - p0, 1);
    check("mid_new_data", sent_q.size() > 0 ? sent_q[$] : 8'hxx, 8'h3C);
    wait_rx(2, 200, "mid_rx_timeout");
    check("mid_rx_byte", rx_q.size() > 1 ? rx_q[1] : 8'hxx, 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte FIFO and handshake sequencer that sits directly upstream of the UART transmit controller. Producer logic writes bytes at full clock rate. The block buffers them and issues them one at a time over the controller's `send`/`data`/`ready` handshake, so back-to-back bytes leave the serial line with no producer-side flow control beyond `full`.

## Interface
- `DEPTH`, 16: FIFO entries; must be a power of two, at least 2.
- `ADDR_W`, 4: log2(`DEPTH`).
- `clk`  in  1: system clock (100 MHz).
- `rst`  in  1: asynchronous, active-high reset.
- `wr_en`  in  1: write strobe; one byte per cycle.
- `wr_data`  in  8: byte to enqueue.
- `ovf_clr`  in  1: clears the `overflow` flag.
- `tx_ready`  in  1: `ready` from the transmit controller; high while that controller is idle.
- `tx_send`  out  1: `send` to the transmit controller; a one-cycle pulse.
- `tx_data`  out  8: `data` to the transmit controller; held stable from the `tx_send` pulse until the next pulse.
- `full`  out  1: FIFO holds `DEPTH` bytes.
- `empty`  out  1: FIFO holds 0 bytes.
- `count`  out  `ADDR_W`+1: bytes currently buffered, 0..`DEPTH`.
- `overflow`  out  1: sticky flag; set by a rejected write.

## Operation
- **FIFO storage**: circular buffer with `rd_ptr` and `wr_ptr`, each `ADDR_W` bits, wrapping modulo `DEPTH`.
  - `count` is held in a separate `ADDR_W`+1 bit register.
  - `full` = (`count` == `DEPTH`); `empty` = (`count` == 0).
- **Write**: accepted when `wr_en` && !`full`. The byte is stored at `wr_ptr`, then `wr_ptr` increments.
- **Rejected write**: `wr_en` && `full` drops the byte and sets `overflow`.
  - A write is rejected whenever `full` is high, even if a pop occurs in the same cycle.
- **Overflow clear**: `ovf_clr` clears `overflow`. If `ovf_clr` and a rejected write occur in the same cycle, set wins.
- **Pop**: occurs only in the IDLE→SEND transition.
  - On a pop, `tx_data` <= mem[`rd_ptr`] and `rd_ptr` increments.
  - Simultaneous accepted write and pop: `count` is unchanged.
- **FSM states**: IDLE, SEND, WAIT_BUSY, WAIT_RDY.
  - IDLE: if !`empty` && `tx_ready`, pop and go to SEND. Otherwise stay.
  - SEND: `tx_send` = 1 for exactly this cycle; go to WAIT_BUSY unconditionally.
  - WAIT_BUSY: wait for `tx_ready` == 0, meaning the controller has latched the byte, then go to WAIT_RDY.
  - WAIT_RDY: wait for `tx_ready` == 1, meaning the frame is complete, then go to IDLE.
- **Output timing**: `tx_send` is decoded from a registered state (state == SEND), so it is glitch-free and one cycle wide.
- **Data hold**: `tx_data` is registered and changes only on a pop.
- **Reset**: asserting `rst` at any time, including mid-frame, forces the following immediately (asynchronously):
  - state = IDLE, both pointers = 0, `count` = 0.
  - `tx_send` = 0, `tx_data` = 8'h00, `overflow` = 0.
  - `empty` = 1, `full` = 0.
  - Buffered bytes are discarded. The downstream controller has no reset and finishes any frame in flight. The feeder does not send again until it sees `tx_ready` high in IDLE.

## Timing
- **Write latency**: a write in cycle N updates `count` and `empty` in cycle N+1.
  - The earliest pop is in cycle N+1 (IDLE evaluates the registered `empty`).
  - `tx_send` pulses in cycle N+2.
- **Controller latch**: the controller samples `send` while in its RDY state and drops `ready` one cycle after the pulse. WAIT_BUSY therefore normally lasts 1 cycle.
- **Frame length**: 10 bits × (100000000/9600 + 1) cycles ≈ 104,180 cycles.
- **Inter-frame gap**: after `tx_ready` rises, the next `tx_send` follows at cycle +2 (WAIT_RDY→IDLE, then IDLE→SEND). This adds no line idle time beyond the controller's own.
- **Blocked start**: if `tx_ready` is low while in IDLE, no pop occurs and bytes stay queued.
- **Write throughput**: one byte per cycle until `full`.
- **Drain rate**: one byte per frame.

## Test plan
- **Reset values**: assert `rst` for 3 cycles, then release → `empty`=1, `full`=0, `count`=0, `tx_send`=0, `tx_data`=8'h00, `overflow`=0.
- **Single byte**: write 8'hA5 with `tx_ready`=1 → `tx_send` pulses exactly 1 cycle, two cycles after the write, with `tx_data`=8'hA5. Using a behavioural controller model, the serial output decodes as 0xA5.
- **Ordering and draining**: write 8'h01..8'h10 on 16 consecutive cycles → `full`=1 and `count`=16 after the 16th write.
  - Bytes emerge as 8'h01 through 8'h10 in order, one per `tx_ready` rising edge.
  - `empty`=1 after the last pop.
- **Overflow**: with `tx_ready` held 0, write 17 bytes → the 17th is dropped, `overflow`=1, `count`=16.
  - `ovf_clr` then clears `overflow`.
  - Asserting `ovf_clr` together with a rejected write leaves `overflow`=1.
- **Wrap-around**: write 20 bytes in bursts while draining, so both pointers wrap → all 20 bytes are sent in order with no loss and no duplicates.
  - At least one cycle must have a simultaneous write and pop; `count` must be unchanged in that cycle.
- **Reset mid-operation**: with 5 bytes queued and one frame in flight, assert `rst` for 1 cycle → `tx_send` stays 0, `count`=0, and no further pulses occur.
  - A new byte 8'h3C written afterwards is sent only after `tx_ready` returns high.
